// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies, FSM encoding.
package mdu_pkg;

    localparam int unsigned MDU_OP_W            = 3;
    localparam int unsigned MDU_DEF_WIDTH       = 32;
    localparam int unsigned MDU_DEF_MULT_CYCLES = 5;
    localparam int unsigned MDU_DEF_DIV_CYCLES  = 10;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// E-stage command bus into the MDU and its HI/LO / status return path.
interface mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       mdu_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, mdu_op, src_a, src_b, req,
                    input  busy, done, hi, lo);
    modport slave  (input  start, mdu_op, src_a, src_b, req,
                    output busy, done, hi, lo);
endinterface

// File: rtl/mdu_compute.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
module mdu_compute
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res,
    output logic             div_zero
);
    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    prod_s;
    logic [PW-1:0]    prod_u;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    // Signed division runs on magnitudes; most-negative / -1 wraps naturally.
    always_comb begin
        prod_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u   = {WIDTH'(0), a} * {WIDTH'(0), b};
        div_zero = (b == '0);
        neg_a    = (op == MDU_DIV) && a[WIDTH-1];
        neg_b    = (op == MDU_DIV) && b[WIDTH-1];
        mag_a    = neg_a ? WIDTH'(-a) : a;
        mag_b    = neg_b ? WIDTH'(-b) : b;
        divisor  = div_zero ? WIDTH'(1) : mag_b;
        q_mag    = mag_a / divisor;
        r_mag    = mag_a % divisor;
        quot     = (neg_a ^ neg_b) ? WIDTH'(-q_mag) : q_mag;
        rem      = neg_a ? WIDTH'(-r_mag) : r_mag;
        hi_res   = '0;
        lo_res   = '0;
        case (op)
            MDU_MULT: begin
                hi_res = prod_s[PW-1:WIDTH];
                lo_res = prod_s[WIDTH-1:0];
            end
            MDU_MULTU: begin
                hi_res = prod_u[PW-1:WIDTH];
                lo_res = prod_u[WIDTH-1:0];
            end
            MDU_DIV, MDU_DIVU: begin
                hi_res = rem;
                lo_res = quot;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; results commit after a fixed latency.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = MDU_DEF_WIDTH,
    parameter int unsigned MULT_CYCLES = MDU_DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DEF_DIV_CYCLES
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    localparam int unsigned MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_wr;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] hi_res_c;
    logic [WIDTH-1:0] lo_res_c;
    logic             div_zero_c;
    logic             accept_c;

    mdu_compute #(.WIDTH(WIDTH)) u_compute (
        .op       (bus.mdu_op),
        .a        (bus.src_a),
        .b        (bus.src_b),
        .hi_res   (hi_res_c),
        .lo_res   (lo_res_c),
        .div_zero (div_zero_c)
    );

    assign accept_c = bus.start && !bus.req && (state == IDLE);

    // Command acceptance, latency countdown and HI/LO commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        case (bus.mdu_op)
                            MDU_MULT, MDU_MULTU: begin
                                pend_hi <= hi_res_c;
                                pend_lo <= lo_res_c;
                                pend_wr <= 1'b1;
                                cnt     <= CNT_W'(MULT_CYCLES);
                                busy_q  <= 1'b1;
                                state   <= RUN;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                pend_hi <= hi_res_c;
                                pend_lo <= lo_res_c;
                                pend_wr <= !div_zero_c;
                                cnt     <= CNT_W'(DIV_CYCLES);
                                busy_q  <= 1'b1;
                                state   <= RUN;
                            end
                            MDU_MTHI: hi_q <= bus.src_a;
                            MDU_MTLO: lo_q <= bus.src_a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                        if (pend_wr) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboarded random + directed bench for mdu_unit against an arithmetic HI/LO model.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(W)) bus ();

    mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t         sb_q[$];
    int           checks    = 0;
    int           errors    = 0;
    int           done_seen = 0;
    logic [W-1:0] model_hi  = '0;
    logic [W-1:0] model_lo  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the architectural definition of each op.
    task automatic model_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t            e;
        longint          ps;
        longint unsigned pu;
        int              sa, sb;
        e.hi  = model_hi;
        e.lo  = model_lo;
        e.lat = 0;
        case (op)
            MDU_MULT: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                e.hi = ps[63:32]; e.lo = ps[31:0]; e.lat = MC;
            end
            MDU_MULTU: begin
                pu = {32'b0, a} * {32'b0, b};
                e.hi = pu[63:32]; e.lo = pu[31:0]; e.lat = MC;
            end
            MDU_DIV: begin
                sa = a; sb = b; e.lat = DC;
                if (b == 32'h0) ;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = a; e.hi = 32'h0;
                end else begin
                    e.lo = sa / sb; e.hi = sa % sb;
                end
            end
            MDU_DIVU: begin
                e.lat = DC;
                if (b != 32'h0) begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            MDU_MTHI: e.hi = a;
            MDU_MTLO: e.lo = a;
            default: ;
        endcase
        model_hi = e.hi;
        model_lo = e.lo;
        if (e.lat != 0) sb_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic rq);
        if (!rq) model_cmd(op, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.mdu_op = op; bus.src_a = a; bus.src_b = b; bus.req = rq;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.req = 1'b0;
    endtask

    task automatic wait_done();
        int prev = done_seen;
        int n = 0;
        while (done_seen == prev && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_seen == prev) chk("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle_cycles(input int n, input string name);
        int prev = done_seen;
        repeat (n) @(negedge clk);
        #1;
        chk({name, "_no_done"}, 64'(done_seen), 64'(prev));
        chk({name, "_busy"}, 64'(bus.busy), 64'(0));
    endtask

    // Monitor: count busy cycles and check every commit against the scoreboard.
    initial begin
        int   busy_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.done) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", 64'(1), 64'(0));
                    end else begin
                        e = sb_q.pop_front();
                        chk("commit_hi", 64'(bus.hi), 64'(e.hi));
                        chk("commit_lo", 64'(bus.lo), 64'(e.lo));
                        chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
                    end
                    busy_cnt = 0;
                    done_seen++;
                end
            end
        end
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic         rq;
        bus.start = 1'b0; bus.mdu_op = '0; bus.src_a = '0; bus.src_b = '0; bus.req = 1'b0;
        reset = 1'b1;
        #22;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_hi", 64'(bus.hi), 64'(0));
        chk("rst_lo", 64'(bus.lo), 64'(0));
        reset = 1'b0;

        issue(MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        wait_done();
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done();
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        wait_done();
        issue(MDU_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        wait_done();

        issue(MDU_MTHI, 32'h11, 32'h0, 1'b0);
        chk("mthi_busy", 64'(bus.busy), 64'(0));
        issue(MDU_MTLO, 32'h22, 32'h0, 1'b0);
        chk("mtlo_busy", 64'(bus.busy), 64'(0));
        chk("mthi_hi", 64'(bus.hi), 64'(32'h11));
        chk("mtlo_lo", 64'(bus.lo), 64'(32'h22));
        issue(MDU_DIV, 32'h1234, 32'h0, 1'b0);
        wait_done();
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done();

        issue(MDU_MULT, 32'h7, 32'h9, 1'b1);
        chk("req_busy", 64'(bus.busy), 64'(0));
        idle_cycles(8, "req_mult");
        chk("req_hi", 64'(bus.hi), 64'(model_hi));
        issue(MDU_MTLO, 32'h5, 32'h0, 1'b1);
        chk("req_mtlo_lo", 64'(bus.lo), 64'(model_lo));

        issue(MDU_MULT, 32'h0000_1234, 32'hFFFF_0000, 1'b0);
        @(negedge clk);
        $display("note: protocol violation, start while busy (must be ignored)");
        bus.start = 1'b1; bus.mdu_op = MDU_DIV; bus.src_a = 32'h99; bus.src_b = 32'h3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();
        idle_cycles(14, "ignored_div");

        issue(MDU_DIV, 32'd100, 32'd7, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'(0));
        chk("arst_hi", 64'(bus.hi), 64'(0));
        chk("arst_lo", 64'(bus.lo), 64'(0));
        sb_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        idle_cycles(14, "after_reset");
        chk("after_reset_hi", 64'(bus.hi), 64'(0));

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end
            rq = ($urandom_range(0, 7) == 0);
            issue(op, a, b, rq);
            if (!rq && op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU}) begin
                wait_done();
            end else begin
                chk("rnd_hi", 64'(bus.hi), 64'(model_hi));
                chk("rnd_lo", 64'(bus.lo), 64'(model_lo));
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
